// File: rtl/skinny_inv_superbox32_dom1.sv
// Inverse SKINNY-128 superbox on one column: inverse MixColumns, key add, then four inverse
// S-boxes, first-order DOM masked over two shares with one nonlinear layer per cycle.
module skinny_inv_superbox32_dom1 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] si0,
   input  logic [31:0] si1,
   input  logic [15:0] k0,
   input  logic [15:0] k1,
   input  logic [31:0] r,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] so0,
   output logic [31:0] so1,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StL1   = 3'd1;
   localparam logic [2:0] StL2   = 3'd2;
   localparam logic [2:0] StL3   = 3'd3;
   localparam logic [2:0] StL4   = 3'd4;
   localparam logic [2:0] StDone = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] s0_q, s1_q, rnd_q;

   // Per layer: linear state of each share, DOM inner products and refreshed cross terms.
   logic [31:0] lin0_q [4];
   logic [31:0] lin1_q [4];
   logic [7:0]  inr0_q [4];
   logic [7:0]  inr1_q [4];
   logic [7:0]  crs0_q [4];
   logic [7:0]  crs1_q [4];

   logic [31:0] x0 [4];
   logic [31:0] x1 [4];
   logic [31:0] y0 [4];
   logic [31:0] y1 [4];
   logic [7:0]  ga0 [4];
   logic [7:0]  gb0 [4];
   logic [7:0]  ga1 [4];
   logic [7:0]  gb1 [4];
   logic [3:0]  layer_en;
   logic        accept;

   function automatic logic [31:0] inv_mix_col(input logic [31:0] m);
      logic [31:0] a;
      a[31:24] = m[23:16];
      a[23:16] = m[15:8] ^ m[7:0] ^ m[23:16];
      a[15:8]  = m[7:0] ^ m[23:16];
      a[7:0]   = m[31:24] ^ m[7:0];
      return a;
   endfunction

   function automatic logic [31:0] swap_bits(input logic [31:0] x);
      return (x & 32'hF9F9_F9F9) | ((x >> 1) & 32'h0202_0202) | ((x << 1) & 32'h0404_0404);
   endfunction

   function automatic logic [31:0] perm_inv(input logic [31:0] x);
      return ((x & 32'h0808_0808) << 1) | ((x & 32'h3232_3232) << 2)
           | ((x & 32'h0101_0101) << 5) | ((x & 32'hC0C0_C0C0) >> 5)
           | ((x & 32'h0404_0404) >> 2);
   endfunction

   // Gate 2b targets bit 0 of byte b (inputs bits 3,2); gate 2b+1 targets bit 4 (bits 7,6).
   function automatic logic [7:0] gate_a(input logic [31:0] x);
      logic [7:0] g;
      for (int b = 0; b < 4; b++) begin
         g[2*b]   = x[8*b+3];
         g[2*b+1] = x[8*b+7];
      end
      return g;
   endfunction

   function automatic logic [7:0] gate_b(input logic [31:0] x);
      logic [7:0] g;
      for (int b = 0; b < 4; b++) begin
         g[2*b]   = x[8*b+2];
         g[2*b+1] = x[8*b+6];
      end
      return g;
   endfunction

   function automatic logic [31:0] spread(input logic [7:0] q);
      logic [31:0] e;
      e = '0;
      for (int b = 0; b < 4; b++) begin
         e[8*b]   = q[2*b];
         e[8*b+4] = q[2*b+1];
      end
      return e;
   endfunction

   assign accept    = in_valid & in_ready;
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign layer_en  = {state_q == StL4, state_q == StL3, state_q == StL2, state_q == StL1};
   assign so0       = y0[3];
   assign so1       = y1[3];

   always_comb begin
      for (int l = 0; l < 4; l++) begin
         y0[l] = lin0_q[l] ^ spread(inr0_q[l] ^ crs0_q[l]);
         y1[l] = lin1_q[l] ^ spread(inr1_q[l] ^ crs1_q[l]);
      end
   end

   always_comb begin
      x0[0] = swap_bits(s0_q);
      x1[0] = swap_bits(s1_q);
      for (int l = 1; l < 4; l++) begin
         x0[l] = perm_inv(y0[l-1]);
         x1[l] = perm_inv(y1[l-1]);
      end
   end

   // NOR(a,b) = AND(~a,~b); inverting only share 0 inverts the shared value.
   always_comb begin
      for (int l = 0; l < 4; l++) begin
         ga0[l] = ~gate_a(x0[l]);
         gb0[l] = ~gate_b(x0[l]);
         ga1[l] = gate_a(x1[l]);
         gb1[l] = gate_b(x1[l]);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_valid) state_d = StL1;
         StL1:    state_d = StL2;
         StL2:    state_d = StL3;
         StL3:    state_d = StL4;
         StL4:    state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         s0_q    <= '0;
         s1_q    <= '0;
         rnd_q   <= '0;
         for (int l = 0; l < 4; l++) begin
            lin0_q[l] <= '0;
            lin1_q[l] <= '0;
            inr0_q[l] <= '0;
            inr1_q[l] <= '0;
            crs0_q[l] <= '0;
            crs1_q[l] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            s0_q  <= inv_mix_col(si0) ^ {k0, 16'h0000};
            s1_q  <= inv_mix_col(si1) ^ {k1, 16'h0000};
            rnd_q <= r;
         end
         for (int l = 0; l < 4; l++) begin
            if (layer_en[l]) begin
               lin0_q[l] <= x0[l];
               lin1_q[l] <= x1[l];
               inr0_q[l] <= ga0[l] & gb0[l];
               inr1_q[l] <= ga1[l] & gb1[l];
               crs0_q[l] <= (ga0[l] & gb1[l]) ^ rnd_q[8*l +: 8];
               crs1_q[l] <= (ga1[l] & gb0[l]) ^ rnd_q[8*l +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_skinny_inv_superbox32_dom1.sv
// Scoreboard bench: driver pushes expected unmasked results, a forked monitor checks
// so0^so1 and latency whenever out_valid rises.
module tb_skinny_inv_superbox32_dom1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] si0, si1, r;
   logic [15:0] k0, k1;
   logic        in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] so0, so1;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];
   int          acc_q[$];
   logic [7:0]  sbox [256];
   logic [7:0]  isbox [256];

   skinny_inv_superbox32_dom1 dut (
      .clk       (clk),
      .rst       (rst),
      .si0       (si0),
      .si1       (si1),
      .k0        (k0),
      .k1        (k1),
      .r         (r),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .so0       (so0),
      .so1       (so1),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Forward SKINNY-128 S-box: four NOR-XOR rounds with bit permutations, final bit swap.
   function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
      logic [7:0] x;
      x = v;
      for (int i = 0; i < 4; i++) begin
         x[4] = x[4] ^ ~(x[7] | x[6]);
         x[0] = x[0] ^ ~(x[3] | x[2]);
         if (i < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
         else       x = {x[7:3], x[1], x[2], x[0]};
      end
      return x;
   endfunction

   function automatic logic [31:0] sub_fwd(input logic [31:0] a);
      return {sbox[a[31:24]], sbox[a[23:16]], sbox[a[15:8]], sbox[a[7:0]]};
   endfunction

   function automatic logic [31:0] sub_inv(input logic [31:0] a);
      return {isbox[a[31:24]], isbox[a[23:16]], isbox[a[15:8]], isbox[a[7:0]]};
   endfunction

   // Forward MixColumns: row1^=row2, row2^=row0, row3^=row2, then rotate rows down by one.
   function automatic logic [31:0] mc_fwd(input logic [31:0] a);
      logic [7:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = a;
      w1 = w1 ^ w2;
      w2 = w2 ^ w0;
      w3 = w3 ^ w2;
      return {w3, w0, w1, w2};
   endfunction

   function automatic logic [31:0] mc_inv(input logic [31:0] m);
      logic [7:0] w0, w1, w2, w3;
      {w0, w1, w2, w3} = m;
      return {w1, w2 ^ w3 ^ w1, w3 ^ w1, w0 ^ w3};
   endfunction

   function automatic logic [31:0] ref_model(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [15:0] c0, input logic [15:0] c1);
      return sub_inv(mc_inv(a0 ^ a1) ^ {c0 ^ c1, 16'h0000});
   endfunction

   function automatic logic [15:0] rand16();
      logic [31:0] t;
      t = $urandom;
      return t[15:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor_loop();
      logic        prev;
      logic [31:0] e;
      int          a;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got %h, expected no output", so0 ^ so1);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("result", so0 ^ so1, e);
               check("latency", 32'(cyc - a), 32'd5);
            end
         end
         prev = out_valid;
      end
   endtask

   task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [15:0] c0,
                       input logic [15:0] c1, input logic [31:0] rv, input logic [31:0] exp,
                       input bit bp);
      int guard;
      guard = 0;
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      while (!in_ready && guard < 100) begin
         @(posedge clk);
         #1;
         out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         guard++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      end else begin
         si0 = a0; si1 = a1; k0 = c0; k1 = c1; r = rv;
         in_valid = 1'b1;
         exp_q.push_back(exp);
         acc_q.push_back(cyc);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         si0 = $urandom; si1 = $urandom; k0 = rand16(); k1 = rand16(); r = $urandom;
      end
   endtask

   initial begin
      logic [31:0] x, s, m, mask, t0, t1, h0, h1;
      logic [15:0] kk, kr;
      int          guard;

      for (int v = 0; v < 256; v++) sbox[v] = fwd_sbox(8'(v));
      for (int v = 0; v < 256; v++) isbox[sbox[v]] = 8'(v);

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      si0 = '0; si1 = '0; k0 = '0; k1 = '0; r = '0;
      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_so0", so0, 32'd0);
      check("rst_so1", so1, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      send(32'h6565_0000, 32'd0, 16'd0, 16'd0, 32'd0, 32'h0000_0000, 1'b0);
      send(32'hFFFF_0000, 32'd0, 16'd0, 16'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 200; i++)
         send(32'hC0C0_A5A5, 32'hA5A5_A5A5, 16'd0, 16'd0, $urandom, 32'h0000_0000, 1'b0);

      for (int i = 0; i < 300; i++) begin
         t0 = $urandom; t1 = $urandom; kk = rand16(); kr = rand16();
         send(t0, t1, kk, kr, $urandom, ref_model(t0, t1, kk, kr), 1'b1);
      end

      for (int i = 0; i < 2500; i++) begin
         x = $urandom; kk = rand16(); kr = rand16(); mask = $urandom;
         s = sub_fwd(x);
         m = mc_fwd(s ^ {kk, 16'h0000});
         send(m ^ mask, mask, kk ^ kr, kr, $urandom, x, 1'b1);
      end

      // Back-pressure in DONE with in_valid held high.
      x = $urandom; kk = rand16(); mask = $urandom;
      m = mc_fwd(sub_fwd(x) ^ {kk, 16'h0000});
      send(m ^ mask, mask, kk, 16'd0, $urandom, x, 1'b0);
      out_ready = 1'b0;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
      h0 = so0; h1 = so1;
      check("bp_result", h0 ^ h1, x);
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_so0", so0, h0);
         check("bp_hold_so1", so1, h1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      check("bp_after_so0", so0, h0);
      check("bp_after_so1", so1, h1);

      // Reset pulse while in L3.
      send(32'h1234_5678, 32'h9ABC_DEF0, 16'h1111, 16'h2222, $urandom,
           ref_model(32'h1234_5678, 32'h9ABC_DEF0, 16'h1111, 16'h2222), 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_so0", so0, 32'd0);
      check("midrst_so1", so1, 32'd0);
      exp_q.delete();
      acc_q.delete();
      #2;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
         check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
      end

      for (int i = 0; i < 20; i++) begin
         x = $urandom; kk = rand16(); kr = rand16(); mask = $urandom;
         m = mc_fwd(sub_fwd(x) ^ {kk, 16'h0000});
         send(m ^ mask, mask, kk ^ kr, kr, $urandom, x, 1'b0);
      end

      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      repeat (2) @(negedge clk);
      check("drain", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
